qif_synapse_current: RTL

// - Upstream stage of the QIF neuron: turns pre-synaptic spike events into the signed

---
 rtl/qif_pkg.sv | 25 ++
 rtl/qif_tick_prescaler.sv | 27 ++
 rtl/qif_synapse_current.sv | 129 ++++++++++++
 3 files changed

// File: rtl/qif_pkg.sv
// Shared QIF definitions: datapath width, neuron thresholds, synapse FSM states and saturation.
package qif_pkg;
    localparam int QIF_W   = 8;
    localparam int V_RESET = -20;
    localparam int V_TH    = 50;

    typedef enum logic {
        READY   = 1'b0,
        REFRACT = 1'b1
    } syn_state_t;

    // Clamp x to the two's complement range of a w-bit word.
    function automatic int sat_w(input int x, input int unsigned w);
        int v_max;
        int v_min;
        v_max = (1 <<< (w - 1)) - 1;
        v_min = -(1 <<< (w - 1));
        if (x > v_max) begin
            return v_max;
        end else if (x < v_min) begin
            return v_min;
        end
        return x;
    endfunction
endpackage

// File: rtl/qif_tick_prescaler.sv
// Decay-tick prescaler: modulo-PRESCALE counter, frozen and silent while disabled.
module qif_tick_prescaler #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ena,
    output logic o_tick
);
    localparam int unsigned   CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_ena) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_ena & w_last;
endmodule

// File: rtl/qif_synapse_current.sv
// QIF synaptic current: synchronised spike edge detect, refractory FSM and
// saturating exponential-decay current register feeding the neuron.
module qif_synapse_current
    import qif_pkg::*;
#(
    parameter int unsigned W             = QIF_W,
    parameter int unsigned PRESCALE      = 16,
    parameter int unsigned REFRACT_TICKS = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                spike_in,
    input  logic signed [W-1:0] weight,
    input  logic        [2:0]   tau_shift,
    output logic signed [W-1:0] i_syn,
    output logic                tick,
    output logic                accepted,
    output logic                refractory
);
    localparam int unsigned    RCW      = (REFRACT_TICKS > 1) ? $clog2(REFRACT_TICKS) : 1;
    localparam logic [RCW-1:0] REF_LAST = RCW'((REFRACT_TICKS > 0) ? REFRACT_TICKS - 1 : 0);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_edge;
    logic                   w_tick;
    logic                   w_add;
    syn_state_t             r_state;
    syn_state_t             w_state_nxt;
    logic [RCW-1:0]         r_refcnt;
    logic [RCW-1:0]         w_refcnt_nxt;
    logic signed [W-1:0]    r_isyn;
    logic signed [W-1:0]    w_shr;
    logic signed [W-1:0]    w_decay;
    logic signed [W+1:0]    w_sum;
    logic signed [W-1:0]    w_sat;

    qif_tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ena   (ena),
        .o_tick  (w_tick)
    );

    // Synchroniser and edge history run regardless of ena so that a level
    // already high when ena rises is not mistaken for a new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], spike_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = ena & r_sync[SYNC_STAGES-1] & ~r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= READY;
            r_refcnt <= '0;
        end else if (ena) begin
            r_state  <= w_state_nxt;
            r_refcnt <= w_refcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_refcnt_nxt = r_refcnt;
        w_add        = 1'b0;
        case (r_state)
            READY: begin
                if (w_edge) begin
                    w_add = 1'b1;
                    if (REFRACT_TICKS > 0) begin
                        w_state_nxt  = REFRACT;
                        w_refcnt_nxt = '0;
                    end
                end
            end
            REFRACT: begin
                if (w_tick) begin
                    if (r_refcnt == REF_LAST) begin
                        w_state_nxt = READY;
                    end else begin
                        w_refcnt_nxt = r_refcnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = READY;
        endcase
    end

    // Decay and add share one W+2 bit sum so a coincident tick and spike saturate once.
    always_comb begin
        w_shr   = r_isyn >>> tau_shift;
        w_decay = w_shr;
        if (w_shr == '0 && r_isyn != '0) begin
            w_decay = r_isyn[W-1] ? '1 : W'(1);
        end
        w_sum = (W+2)'(r_isyn);
        if (w_tick) begin
            w_sum = w_sum - (W+2)'(w_decay);
        end
        if (w_add) begin
            w_sum = w_sum + (W+2)'(weight);
        end
        w_sat = W'(sat_w(int'(w_sum), W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_isyn <= '0;
        end else if (ena) begin
            r_isyn <= w_sat;
        end
    end

    assign i_syn      = r_isyn;
    assign tick       = w_tick;
    assign accepted   = w_add;
    assign refractory = (r_state == REFRACT);
endmodule
